// File: rtl/div_iter_unit_if.sv
// div_iter_unit_if: execute-stage <-> divider handshake bundle
// master = execute stage (drives request/operands), slave = divider (drives result/ready/stall)
interface div_iter_unit_if #(parameter int WIDTH = 32);
  logic               start_i;
  logic               signed_i;
  logic               annul_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stall_o;
  modport master (output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
                  input  result_o, ready_o, stall_o);
  modport slave  (input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
                  output result_o, ready_o, stall_o);
endinterface

// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative radix-2 restoring divider, result {remainder, quotient}
// clk, resetn (async active-low); bus.slave: start_i/signed_i/annul_i/opdata1_i/opdata2_i in,
// result_o/ready_o/stall_o out
module div_iter_unit #(parameter int WIDTH = 32) (
  input logic          clk,
  input logic          resetn,
  div_iter_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, BYZERO = 2'd1, ON = 2'd2, END = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic               nq_q, nq_d, nr_q, nr_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]     rem_sh, diff;
  logic [WIDTH-1:0]   abs1, abs2;
  logic               borrow;
  assign abs1   = (bus.signed_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign abs2   = (bus.signed_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
  // partial remainder stays below the divisor, so one extra bit holds the shifted value
  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign borrow = diff[WIDTH];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    res_d   = res_q;
    if (bus.annul_i) begin
      state_d = IDLE;
    end else if (state_q == IDLE && bus.start_i) begin
      state_d = (bus.opdata2_i == '0) ? BYZERO : ON;
      cnt_d   = '0;
      dvd_d   = abs1;
      dvs_d   = abs2;
      rem_d   = '0;
      nq_d    = bus.signed_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
      nr_d    = bus.signed_i & bus.opdata1_i[WIDTH-1];
    end else if (state_q == BYZERO) begin
      state_d = END;
      res_d   = '0;
    end else if (state_q == ON) begin
      // quotient bits shift in from the right as the dividend shifts out
      dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
      rem_d = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = END;
        res_d   = {nr_q ? -rem_d : rem_d, nq_q ? -dvd_d : dvd_d};
      end
    end else if (state_q == END && !bus.start_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      res_q   <= res_d;
    end
  end
  assign bus.result_o = res_q;
  assign bus.ready_o  = (state_q == END);
  assign bus.stall_o  = bus.start_i & ~bus.ready_o;
endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: directed self-checking bench for div_iter_unit
module tb_div_iter_unit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  div_iter_unit_if #(.WIDTH(W)) bus();
  div_iter_unit #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    bus.signed_i = s; bus.opdata1_i = a; bus.opdata2_i = b; bus.start_i = 1'b1;
    #1 chk({tag, "_stall_pre"}, 64'(bus.stall_o), 64'd1);
    tick();
    bus.opdata1_i = ~a; bus.opdata2_i = b + 32'd1; bus.signed_i = ~s;
    repeat (W - 1) tick();
    chk({tag, "_ready_early"}, 64'(bus.ready_o), 64'd0);
    chk({tag, "_stall_busy"}, 64'(bus.stall_o), 64'd1);
    tick();
    chk({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
    chk({tag, "_result"}, bus.result_o, exp);
    chk({tag, "_stall_done"}, 64'(bus.stall_o), 64'd0);
    bus.start_i = 1'b0;
    tick();
    chk({tag, "_idle"}, 64'(bus.ready_o), 64'd0);
    chk({tag, "_hold"}, bus.result_o, exp);
  endtask
  task automatic run_zero(input string tag, input logic s, input logic [31:0] a);
    bus.signed_i = s; bus.opdata1_i = a; bus.opdata2_i = '0; bus.start_i = 1'b1;
    tick();
    chk({tag, "_ready_early"}, 64'(bus.ready_o), 64'd0);
    tick();
    chk({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
    chk({tag, "_result"}, bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    tick();
    chk({tag, "_idle"}, 64'(bus.ready_o), 64'd0);
  endtask
  initial begin
    int seen;
    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.annul_i = 1'b0;
    bus.opdata1_i = '0; bus.opdata2_i = '0;
    #2;
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    bus.start_i = 1'b1;
    #1 chk("rst_stall_start", 64'(bus.stall_o), 64'd1);
    bus.start_i = 1'b0;
    #9 resetn = 1'b1;
    tick();
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD});
    run_div("div_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3});
    run_div("divu_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC});
    run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
    run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF});
    bus.signed_i = 1'b0; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3; bus.start_i = 1'b1;
    tick();
    repeat (9) tick();
    bus.annul_i = 1'b1; bus.start_i = 1'b0;
    tick();
    bus.annul_i = 1'b0;
    chk("annul_ready", 64'(bus.ready_o), 64'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.ready_o) seen++;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    chk("annul_hold", bus.result_o, {32'd0, 32'hFFFFFFFF});
    run_div("divu_1000_3", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});
    run_zero("zero_u", 1'b0, 32'd55);
    run_div("divu_100_7b", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    run_zero("zero_s", 1'b1, 32'hFFFFFF00);
    run_div("divu_100_7c", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    bus.signed_i = 1'b0; bus.opdata1_i = 32'd500; bus.opdata2_i = 32'd9; bus.start_i = 1'b1;
    tick();
    repeat (5) tick();
    #2 resetn = 1'b0;
    #1;
    chk("midrst_result", bus.result_o, 64'd0);
    chk("midrst_ready", 64'(bus.ready_o), 64'd0);
    chk("midrst_stall_start", 64'(bus.stall_o), 64'd1);
    bus.start_i = 1'b0;
    #1 chk("midrst_stall", 64'(bus.stall_o), 64'd0);
    resetn = 1'b1;
    tick();
    chk("midrst_idle", 64'(bus.ready_o), 64'd0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
